// File: rtl/dst_wb_pkg.sv
// Shared types for the blitter destination write-back unit: FSM states,
// nybble mask encodings, FIFO entry layout and the nybble merge helper.
package dst_wb_pkg;

    localparam int unsigned ADDR_MAX_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_WRITE
    } wb_state_t;

    localparam logic [1:0] NM_NONE = 2'b00;
    localparam logic [1:0] NM_LO   = 2'b01;
    localparam logic [1:0] NM_HI   = 2'b10;
    localparam logic [1:0] NM_BYTE = 2'b11;

    typedef struct packed {
        logic [ADDR_MAX_W-1:0] addr;
        logic [7:0]            data;
        logic [1:0]            nmask;
    } wb_entry_t;

    // Enabled nybbles come from the new data, the rest from the captured read.
    function automatic logic [7:0] nyb_merge(input logic [7:0] data,
                                             input logic [7:0] cap,
                                             input logic [1:0] nmask);
        return {nmask[1] ? data[7:4] : cap[7:4],
                nmask[0] ? data[3:0] : cap[3:0]};
    endfunction

endpackage

// File: rtl/dst_wb_fifo.sv
// Strict-order write buffer; exposes the head entry and the one behind it
// so the parent can chain accesses without a bus-idle cycle.
module dst_wb_fifo
    import dst_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wb_entry_t              wr_entry,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output wb_entry_t              head,
    output wb_entry_t              head_next
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/dst_writeback.sv
// Blitter destination write-back: buffers destination bytes and writes them
// to memory under bus request/grant, using read-modify-write for nybble masks.
module dst_writeback
    import dst_wb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              MasterClock,
    input  logic              Reset,
    input  logic              WR_REQ,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [7:0]        WR_DATA,
    input  logic [1:0]        WR_NMASK,
    output logic              WR_RDY,
    output logic              IDLE,
    output logic              MEM_BREQ,
    input  logic              MEM_BGNT,
    output logic [ADDR_W-1:0] MEM_A,
    output logic [7:0]        MEM_DOUT,
    input  logic [7:0]        MEM_DIN,
    output logic              MEM_RD,
    output logic              MEM_WR,
    input  logic              MEM_WAIT
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned WC_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    wb_state_t         state_q, state_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic [7:0]        cap_q;
    logic [CNT_W-1:0]  count;
    wb_entry_t         head, head_next, wr_entry, cur;
    logic              push, pop, strobe_q, strobe_d, last;
    logic [7:0]        cap_src;
    logic              breq_d, rd_d, wr_d;
    logic [ADDR_W-1:0] a_d;
    logic [7:0]        dout_d;

    function automatic wb_state_t access_state(input logic [1:0] nmask);
        case (nmask)
            NM_LO, NM_HI: return S_READ;
            NM_BYTE:      return S_WRITE;
            default:      return S_IDLE;
        endcase
    endfunction

    assign WR_RDY   = (count < CNT_W'(DEPTH)) && !Reset;
    assign IDLE     = (count == '0) && (state_q == S_IDLE);
    assign push     = WR_REQ && WR_RDY;
    assign wr_entry = '{addr: ADDR_MAX_W'(WR_ADDR), data: WR_DATA, nmask: WR_NMASK};

    dst_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (MasterClock),
        .rst       (Reset),
        .push      (push),
        .wr_entry  (wr_entry),
        .pop       (pop),
        .count     (count),
        .head      (head),
        .head_next (head_next)
    );

    // Next state plus next values of every registered bus output.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        pop      = 1'b0;
        cur      = head;
        cap_src  = cap_q;
        strobe_q = (state_q == S_READ) || (state_q == S_WRITE);
        last     = strobe_q && (wait_q == '0) && !MEM_WAIT;

        if (strobe_q && (wait_q != '0)) wait_d = wait_q - WC_W'(1);

        case (state_q)
            S_IDLE: begin
                if (count != '0) begin
                    if (head.nmask == NM_NONE) pop = 1'b1;
                    else                       state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (MEM_BGNT) state_d = access_state(head.nmask);
            end
            S_READ: begin
                if (last) begin
                    state_d = S_WRITE;
                    cap_src = MEM_DIN;
                end
            end
            S_WRITE: begin
                if (last) begin
                    pop = 1'b1;
                    cur = head_next;
                    // Chain into the next entry while still owning the bus.
                    if ((count > CNT_W'(1)) && (head_next.nmask != NM_NONE))
                        state_d = MEM_BGNT ? access_state(head_next.nmask) : S_REQ;
                    else
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        strobe_d = (state_d == S_READ) || (state_d == S_WRITE);
        if (strobe_d && (!strobe_q || last)) wait_d = WC_W'(WAIT_CYCLES);

        breq_d = (state_d != S_IDLE);
        rd_d   = (state_d == S_READ);
        wr_d   = (state_d == S_WRITE);
        a_d    = strobe_d ? ADDR_W'(cur.addr) : '0;
        dout_d = wr_d ? nyb_merge(cur.data, cap_src, cur.nmask) : '0;
    end

    always_ff @(posedge MasterClock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            cap_q    <= '0;
            MEM_BREQ <= 1'b0;
            MEM_RD   <= 1'b0;
            MEM_WR   <= 1'b0;
            MEM_A    <= '0;
            MEM_DOUT <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            if ((state_q == S_READ) && last) cap_q <= MEM_DIN;
            MEM_BREQ <= breq_d;
            MEM_RD   <= rd_d;
            MEM_WR   <= wr_d;
            MEM_A    <= a_d;
            MEM_DOUT <= dout_d;
        end
    end

endmodule

// File: tb/tb_dst_writeback.sv
// Directed bench for dst_writeback: hand-computed expectations checked with
// immediate assertions one clock step at a time.
module tb_dst_writeback;

    localparam int unsigned ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [1:0]        wr_nmask;
    logic              wr_rdy;
    logic              idle;
    logic              mem_breq;
    logic              mem_bgnt;
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_dout;
    logic [7:0]        mem_din;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_wait;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    dst_writeback #(.ADDR_W(ADDR_W), .DEPTH(2), .WAIT_CYCLES(1)) dut (
        .MasterClock (clk),
        .Reset       (rst),
        .WR_REQ      (wr_req),
        .WR_ADDR     (wr_addr),
        .WR_DATA     (wr_data),
        .WR_NMASK    (wr_nmask),
        .WR_RDY      (wr_rdy),
        .IDLE        (idle),
        .MEM_BREQ    (mem_breq),
        .MEM_BGNT    (mem_bgnt),
        .MEM_A       (mem_a),
        .MEM_DOUT    (mem_dout),
        .MEM_DIN     (mem_din),
        .MEM_RD      (mem_rd),
        .MEM_WR      (mem_wr),
        .MEM_WAIT    (mem_wait)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic [1:0] m);
        wr_req   = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_nmask = m;
        tick();
        wr_req   = 1'b0;
    endtask

    // Nybble RMW: two read cycles then two write cycles carrying the merge.
    task automatic rmw(input logic [1:0] m, input logic [7:0] exp_dout, input string tag);
        mem_din = 8'h96;
        push_one(20'h00100, 8'h3C, m);
        tick();
        chk({tag, "_breq"}, 32'(mem_breq), 32'd1);
        tick();
        chk({tag, "_rd1"}, 32'(mem_rd), 32'd1);
        chk({tag, "_rd_a"}, 32'(mem_a), 32'h00100);
        chk({tag, "_rd_dout"}, 32'(mem_dout), 32'h0);
        chk({tag, "_rd_nowr"}, 32'(mem_wr), 32'd0);
        tick();
        chk({tag, "_rd2"}, 32'(mem_rd), 32'd1);
        tick();
        chk({tag, "_wr_rdoff"}, 32'(mem_rd), 32'd0);
        chk({tag, "_wr1"}, 32'(mem_wr), 32'd1);
        chk({tag, "_dout"}, 32'(mem_dout), 32'(exp_dout));
        tick();
        chk({tag, "_wr2"}, 32'(mem_wr), 32'd1);
        tick();
        chk({tag, "_wr_end"}, 32'(mem_wr), 32'd0);
        chk({tag, "_idle"}, 32'(idle), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        wr_req   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_nmask = '0;
        mem_bgnt = 1'b1;
        mem_din  = '0;
        mem_wait = 1'b0;
        tick();
        tick();

        chk("rst_breq", 32'(mem_breq), 32'd0);
        chk("rst_rd",   32'(mem_rd),   32'd0);
        chk("rst_wr",   32'(mem_wr),   32'd0);
        chk("rst_a",    32'(mem_a),    32'd0);
        chk("rst_dout", 32'(mem_dout), 32'd0);
        chk("rst_idle", 32'(idle),     32'd1);
        chk("rst_rdy",  32'(wr_rdy),   32'd0);
        rst = 1'b0;
        #1;
        chk("rel_rdy", 32'(wr_rdy), 32'd1);

        // Full-byte write
        push_one(20'h12345, 8'hA5, 2'b11);
        chk("fb_busy", 32'(idle), 32'd0);
        chk("fb_breq0", 32'(mem_breq), 32'd0);
        tick();
        chk("fb_breq1", 32'(mem_breq), 32'd1);
        chk("fb_nowr", 32'(mem_wr), 32'd0);
        tick();
        chk("fb_wr1", 32'(mem_wr), 32'd1);
        chk("fb_a", 32'(mem_a), 32'h12345);
        chk("fb_dout", 32'(mem_dout), 32'hA5);
        chk("fb_nord", 32'(mem_rd), 32'd0);
        tick();
        chk("fb_wr2", 32'(mem_wr), 32'd1);
        chk("fb_nord2", 32'(mem_rd), 32'd0);
        tick();
        chk("fb_wr_end", 32'(mem_wr), 32'd0);
        chk("fb_breq_end", 32'(mem_breq), 32'd0);
        chk("fb_a_end", 32'(mem_a), 32'd0);
        chk("fb_idle", 32'(idle), 32'd1);

        rmw(2'b01, 8'h9C, "rmw_lo");
        rmw(2'b10, 8'h36, "rmw_hi");

        // Mask 00 is dropped without bus activity
        push_one(20'h00200, 8'hFF, 2'b00);
        chk("m0_busy", 32'(idle), 32'd0);
        chk("m0_breq0", 32'(mem_breq), 32'd0);
        tick();
        chk("m0_idle", 32'(idle), 32'd1);
        chk("m0_breq1", 32'(mem_breq), 32'd0);
        chk("m0_rd", 32'(mem_rd), 32'd0);
        chk("m0_wr", 32'(mem_wr), 32'd0);
        tick();
        chk("m0_breq2", 32'(mem_breq), 32'd0);
        chk("m0_wr2", 32'(mem_wr), 32'd0);

        // Back-to-back with delayed grant
        mem_bgnt = 1'b0;
        push_one(20'h00010, 8'h11, 2'b11);
        push_one(20'h00011, 8'h22, 2'b11);
        chk("bb_full", 32'(wr_rdy), 32'd0);
        chk("bb_breq", 32'(mem_breq), 32'd1);
        wr_req   = 1'b1;
        wr_addr  = 20'h00012;
        wr_data  = 8'h33;
        wr_nmask = 2'b11;
        tick();
        tick();
        tick();
        chk("bb_nogrant_wr", 32'(mem_wr), 32'd0);
        chk("bb_still_full", 32'(wr_rdy), 32'd0);
        mem_bgnt = 1'b1;
        tick();
        chk("bb_w1", 32'(mem_wr), 32'd1);
        chk("bb_w1_a", 32'(mem_a), 32'h00010);
        chk("bb_w1_d", 32'(mem_dout), 32'h11);
        tick();
        tick();
        chk("bb_w2", 32'(mem_wr), 32'd1);
        chk("bb_w2_a", 32'(mem_a), 32'h00011);
        chk("bb_w2_d", 32'(mem_dout), 32'h22);
        chk("bb_w2_breq", 32'(mem_breq), 32'd1);
        chk("bb_rdy_after_pop", 32'(wr_rdy), 32'd1);
        tick();
        wr_req = 1'b0;
        chk("bb_third_taken", 32'(wr_rdy), 32'd0);
        chk("bb_w2_hold", 32'(mem_a), 32'h00011);
        tick();
        chk("bb_w3", 32'(mem_wr), 32'd1);
        chk("bb_w3_a", 32'(mem_a), 32'h00012);
        chk("bb_w3_d", 32'(mem_dout), 32'h33);
        chk("bb_w3_breq", 32'(mem_breq), 32'd1);
        tick();
        tick();
        chk("bb_end_wr", 32'(mem_wr), 32'd0);
        chk("bb_end_breq", 32'(mem_breq), 32'd0);
        chk("bb_end_idle", 32'(idle), 32'd1);

        // Wait extension: MEM_WAIT high on the three edges after the base strobe
        push_one(20'h0ABCD, 8'h5A, 2'b11);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("wt_wr%0d", i), 32'(mem_wr), 32'd1);
            chk($sformatf("wt_a%0d", i), 32'(mem_a), 32'h0ABCD);
            chk($sformatf("wt_d%0d", i), 32'(mem_dout), 32'h5A);
            if (i == 1) mem_wait = 1'b1;
            if (i == 4) mem_wait = 1'b0;
        end
        tick();
        chk("wt_end", 32'(mem_wr), 32'd0);
        chk("wt_idle", 32'(idle), 32'd1);

        // Reset in the middle of a write
        push_one(20'h0F0F0, 8'h77, 2'b11);
        tick();
        tick();
        chk("rm_wr", 32'(mem_wr), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rm_wr_drop", 32'(mem_wr), 32'd0);
        chk("rm_breq_drop", 32'(mem_breq), 32'd0);
        chk("rm_a_drop", 32'(mem_a), 32'd0);
        chk("rm_rdy", 32'(wr_rdy), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rm_idle", 32'(idle), 32'd1);
        chk("rm_rdy_rel", 32'(wr_rdy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rm_quiet_wr%0d", i), 32'(mem_wr), 32'd0);
            chk($sformatf("rm_quiet_breq%0d", i), 32'(mem_breq), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
